// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared ALU types and constants
// Purpose: state enumeration for the sequential divider and the default
//          operand width shared with the multiplier and adder paths.
// Ports:   none (package).
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result bundle of the sequential divider
// Purpose: groups the start request, operands and registered results.
// Ports:   Start/A/B (requester -> divider);
//          Quotient/Remainder/Busy/Done/DivByZero (divider -> requester).
//          master = requester side, slave = divider side.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Start, A, B,
    input  Quotient, Remainder, Busy, Done, DivByZero
  );

  modport slave (
    input  Start, A, B,
    output Quotient, Remainder, Busy, Done, DivByZero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division iteration
// Purpose: shifts the next dividend bit into the partial remainder and
//          subtracts the divisor when it fits.
// Ports:   r_in  partial remainder (WIDTH+1)
//          q_in  next dividend bit
//          d_in  divisor (WIDTH)
//          r_out new partial remainder (WIDTH+1)
//          q_bit quotient bit produced by this iteration
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   r_in,
  input  logic             q_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH:0]   r_out,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic             unused_msb;

  // The partial remainder is always below the divisor between iterations,
  // so its top bit is zero and is shifted out.
  assign shifted    = {r_in[WIDTH-1:0], q_in};
  assign unused_msb = r_in[WIDTH];

  // Subtract with one extra bit: the borrow-out is the "does not fit" compare.
  assign diff   = {1'b0, shifted} - {2'b00, d_in};
  assign borrow = diff[WIDTH+1];

  assign q_bit = ~borrow;
  assign r_out = borrow ? shifted : diff[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned restoring divider, one bit per clock
// Purpose: accepts A/B on Start in IDLE, iterates WIDTH cycles, then pulses
//          Done with registered Quotient/Remainder. B=0 completes at once
//          with Quotient=all ones, Remainder=A, DivByZero=1.
// Ports:   Clk  rising-edge clock
//          Rst  asynchronous active-high reset
//          bus  seq_divider_if.slave (Start, A, B in; results, Busy, Done out)
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic         Clk,
  input logic         Rst,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;       // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] d_q, d_d;       // captured divisor
  logic [WIDTH:0]   r_q, r_d;       // partial remainder
  logic [CW-1:0]    cnt_q, cnt_d;   // iterations left
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_r;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q),
    .q_in  (q_q[WIDTH-1]),
    .d_in  (d_q),
    .r_out (step_r),
    .q_bit (step_q)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          if (bus.B == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = bus.A;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            q_d     = bus.A;
            d_d     = bus.B;
            r_d     = '0;
            cnt_d   = CW'(WIDTH);
            busy_d  = 1'b1;
          end
        end
      end

      RUN: begin
        q_d   = {q_q[WIDTH-2:0], step_q};
        r_d   = step_r;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          quot_d  = q_d;
          rem_d   = step_r[WIDTH-1:0];
          dbz_d   = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Quotient  = quot_q;
  assign bus.Remainder = rem_q;
  assign bus.DivByZero = dbz_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;

endmodule
